// File: rtl/display_scan_controller_if.sv
// Game-side bundle for the display scan controller.
//   master: game logic drives game_state, guess_digits, J1_points, J2_points,
//           bull_count, cow_count, result_valid; observes AN/DDP.
//   slave : the scan controller consumes the game signals and drives AN/DDP.
interface display_scan_controller_if;
  logic [2:0]  game_state;
  logic [15:0] guess_digits;
  logic [7:0]  J1_points;
  logic [7:0]  J2_points;
  logic [2:0]  bull_count;
  logic [2:0]  cow_count;
  logic        result_valid;
  logic [7:0]  AN;
  logic [7:0]  DDP;

  modport master (
    output game_state, guess_digits, J1_points, J2_points,
           bull_count, cow_count, result_valid,
    input  AN, DDP
  );

  modport slave (
    input  game_state, guess_digits, J1_points, J2_points,
           bull_count, cow_count, result_valid,
    output AN, DDP
  );
endinterface

// File: rtl/display_scan_controller.sv
// 8-digit multiplexed 7-segment scan controller for Bulls and Cows.
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : game inputs (state, guess, scores, bull/cow result) and the
//           active-low anode (AN) / segment (DDP) outputs.
// One digit is lit per DIV-cycle slot, rightmost (digit 0) first. After a
// guess the bull/cow result overlays the screen for HOLD_FRAMES frames; in
// the win states the display blinks every BLINK_FRAMES frames.
module display_scan_controller #(
  parameter int unsigned DIV          = 100000,
  parameter int unsigned HOLD_FRAMES  = 250,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input logic                      clock,
  input logic                      reset,
  display_scan_controller_if.slave bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Symbol codes: 0-15 are hex digits, the rest are letters / blank.
  localparam logic [4:0] SYM_J     = 5'd16;
  localparam logic [4:0] SYM_C_LOW = 5'd17;
  localparam logic [4:0] SYM_BLANK = 5'd18;

  typedef enum logic {NORMAL, RESULT} mode_t;

  mode_t          mode;
  logic [PW-1:0]  presc;
  logic [2:0]     idx;
  logic [HW-1:0]  hold;
  logic [BW-1:0]  blink_cnt;
  logic           blink_on;
  logic [2:0]     bull_l;
  logic [2:0]     cow_l;
  logic [2:0]     gs_prev;
  logic [7:0]     an_q;
  logic [7:0]     ddp_q;

  logic           tick;
  logic           frame;
  logic           is_win;
  logic           gs_changed;
  logic           blank;
  logic [4:0]     sym;
  logic [7:0]     pts;
  logic [7:0]     glyph;

  function automatic logic [7:0] glyph_of(input logic [4:0] s);
    case (s)
      5'd0:  return 8'hC0;
      5'd1:  return 8'hF9;
      5'd2:  return 8'hA4;
      5'd3:  return 8'hB0;
      5'd4:  return 8'h99;
      5'd5:  return 8'h92;
      5'd6:  return 8'h82;
      5'd7:  return 8'hF8;
      5'd8:  return 8'h80;
      5'd9:  return 8'h90;
      5'd10: return 8'h88;
      5'd11: return 8'h83;
      5'd12: return 8'hC6;
      5'd13: return 8'hA1;
      5'd14: return 8'h86;
      5'd15: return 8'h8E;
      5'd16: return 8'hE1;
      5'd17: return 8'hA7;
      default: return 8'hFF;
    endcase
  endfunction

  assign tick       = (presc == PW'(DIV - 1));
  assign frame      = tick && (idx == 3'd7);
  assign is_win     = (bus.game_state == 3'd4) || (bus.game_state == 3'd5);
  assign gs_changed = (bus.game_state != gs_prev);
  // Blanking looks at the live game_state so leaving a win state mid-blink
  // restores the scan on the very next slot.
  assign blank      = (bus.game_state[2] && bus.game_state[1]) ||
                      (is_win && !blink_on);

  always_comb begin
    sym = SYM_BLANK;
    pts = bus.game_state[0] ? bus.J2_points : bus.J1_points;
    if (mode == RESULT) begin
      case (idx)
        3'd7: sym = 5'd11;
        3'd6: sym = {2'b00, bull_l};
        3'd4: sym = SYM_C_LOW;
        3'd3: sym = {2'b00, cow_l};
        default: sym = SYM_BLANK;
      endcase
    end else if (!bus.game_state[2]) begin
      case (idx)
        3'd7: sym = SYM_J;
        3'd6: sym = {4'b0000, bus.game_state[0]} + 5'd1;
        3'd5, 3'd4: sym = SYM_BLANK;
        default: sym = {1'b0, bus.guess_digits[{idx[1:0], 2'b00} +: 4]};
      endcase
    end else if (is_win) begin
      case (idx)
        3'd7: sym = SYM_J;
        3'd6: sym = {4'b0000, bus.game_state[0]} + 5'd1;
        3'd1: sym = {1'b0, pts[7:4]};
        3'd0: sym = {1'b0, pts[3:0]};
        default: sym = SYM_BLANK;
      endcase
    end
    glyph = glyph_of(sym);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      idx       <= '0;
      mode      <= NORMAL;
      hold      <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      bull_l    <= '0;
      cow_l     <= '0;
      gs_prev   <= '0;
      an_q      <= '1;
      ddp_q     <= '1;
    end else begin
      gs_prev <= bus.game_state;
      presc   <= tick ? '0 : presc + 1'b1;

      // The slot for digit idx is rendered on the tick that leaves idx, so
      // AN/DDP stay frozen for a whole slot and never tear.
      if (tick) begin
        idx <= idx + 1'b1;
        if (blank) begin
          an_q  <= '1;
          ddp_q <= '1;
        end else begin
          an_q  <= ~(8'd1 << idx);
          ddp_q <= glyph;
        end
      end

      case (mode)
        NORMAL: begin
          if (bus.result_valid) begin
            bull_l <= bus.bull_count;
            cow_l  <= bus.cow_count;
            hold   <= HW'(HOLD_FRAMES);
            mode   <= RESULT;
          end
        end
        RESULT: begin
          if (bus.result_valid) begin
            bull_l <= bus.bull_count;
            cow_l  <= bus.cow_count;
            hold   <= HW'(HOLD_FRAMES);
          end else if (gs_changed) begin
            hold <= '0;
            mode <= NORMAL;
          end else if (frame) begin
            if (hold <= HW'(1)) begin
              hold <= '0;
              mode <= NORMAL;
            end else begin
              hold <= hold - 1'b1;
            end
          end
        end
        default: mode <= NORMAL;
      endcase

      if (!is_win) begin
        blink_on  <= 1'b1;
        blink_cnt <= '0;
      end else if (frame) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_on  <= ~blink_on;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.AN  = an_q;
  assign bus.DDP = ddp_q;

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

  localparam int unsigned DIV   = 4;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned BLINK = 2;
  localparam int unsigned FRAME = 8 * DIV;

  localparam logic [7:0] GLY [19] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
    8'hE1, 8'hA7, 8'hFF
  };

  logic clock = 1'b0;
  logic reset = 1'b0;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .DIV          (DIV),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [15:0] expq [$];

  // Reference model state (expressed in cycles and frames since reset).
  int unsigned cyc = 0;
  logic        res_active = 1'b0;
  int unsigned res_base = 0;
  logic [2:0]  m_bull = '0;
  logic [2:0]  m_cow = '0;
  logic [2:0]  m_prev = '0;
  logic        in_win = 1'b0;
  int unsigned win_base = 0;
  logic [7:0]  m_an = 8'hFF;
  logic [7:0]  m_ddp = 8'hFF;

  function automatic int unsigned frames_before(input int unsigned c);
    return c / FRAME;
  endfunction

  // Build the whole 8-digit picture, then pick the digit being lit.
  function automatic logic [7:0] picture(input int unsigned digit, input int unsigned gs,
                                         input logic result, input int unsigned bull,
                                         input int unsigned cow, input int unsigned guess,
                                         input int unsigned j1, input int unsigned j2);
    int unsigned s [8];
    int unsigned p;
    for (int k = 0; k < 8; k++) s[k] = 18;
    if (result) begin
      s[7] = 11; s[6] = bull; s[4] = 17; s[3] = cow;
    end else if (gs < 4) begin
      s[7] = 16; s[6] = gs % 2 + 1;
      for (int k = 0; k < 4; k++) s[k] = (guess >> (4 * k)) % 16;
    end else begin
      p = (gs == 4) ? j1 : j2;
      s[7] = 16; s[6] = gs % 2 + 1; s[1] = p / 16; s[0] = p % 16;
    end
    return GLY[s[digit]];
  endfunction

  always @(posedge clock) begin : model
    int unsigned gs;
    int unsigned digit;
    logic        tick;
    logic        win;
    logic        blink_on;
    logic        showing;
    if (!reset) begin
      cyc = 0; res_active = 1'b0; m_prev = '0; in_win = 1'b0;
      m_an = 8'hFF; m_ddp = 8'hFF;
    end else begin
      gs    = bus.game_state;
      tick  = (cyc % DIV) == DIV - 1;
      digit = (cyc / DIV) % 8;
      win   = (gs == 4) || (gs == 5);
      if (!win) in_win = 1'b0;
      else if (!in_win) begin
        in_win = 1'b1;
        win_base = frames_before(cyc);
      end
      blink_on = !win || ((((frames_before(cyc) - win_base) / BLINK) % 2) == 0);
      showing  = res_active && ((frames_before(cyc) - res_base) < HOLD);
      if (tick) begin
        if (gs >= 6 || !blink_on) begin
          m_an = 8'hFF; m_ddp = 8'hFF;
        end else begin
          m_an  = ~(8'd1 << digit);
          m_ddp = picture(digit, gs, showing, m_bull, m_cow, bus.guess_digits,
                          bus.J1_points, bus.J2_points);
        end
      end
      if (bus.result_valid) begin
        res_active = 1'b1;
        res_base   = frames_before(cyc + 1);
        m_bull     = bus.bull_count;
        m_cow      = bus.cow_count;
      end else if (showing && gs != m_prev) begin
        res_active = 1'b0;
      end
      m_prev = bus.game_state;
      cyc++;
    end
    expq.push_back({m_an, m_ddp});
  end

  always @(negedge clock) begin : monitor
    logic [15:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      if (bus.AN !== e[15:8] || (e[15:8] != 8'hFF && bus.DDP !== e[7:0])) begin
        miscompares++;
        $display("FAIL scan t=%0t AN got %h exp %h DDP got %h exp %h",
                 $time, bus.AN, e[15:8], bus.DDP, e[7:0]);
      end
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_result(input logic [2:0] b, input logic [2:0] c);
    @(negedge clock);
    bus.result_valid = 1'b1;
    bus.bull_count   = b;
    bus.cow_count    = c;
    @(negedge clock);
    bus.result_valid = 1'b0;
  endtask

  initial begin
    bus.game_state   = 3'd0;
    bus.guess_digits = 16'h1234;
    bus.J1_points    = 8'h00;
    bus.J2_points    = 8'h00;
    bus.bull_count   = 3'd0;
    bus.cow_count    = 3'd0;
    bus.result_valid = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2 * FRAME + 10);

    // Result overlay, full hold.
    bus.game_state = 3'd2;
    wait_cycles(5);
    pulse_result(3'd2, 3'd1);
    wait_cycles(4 * FRAME);

    // Abort by game_state change.
    pulse_result(3'd5, 3'd3);
    wait_cycles(10);
    bus.game_state = 3'd3;
    wait_cycles(2 * FRAME);

    // Reload during overlay.
    bus.game_state = 3'd2;
    pulse_result(3'd2, 3'd1);
    wait_cycles(2 * FRAME);
    pulse_result(3'd4, 3'd0);
    wait_cycles(5 * FRAME);

    // Win states and blink.
    bus.game_state = 3'd4;
    bus.J1_points  = 8'h0A;
    wait_cycles(9 * FRAME + 7);
    bus.game_state = 3'd5;
    bus.J2_points  = 8'h3C;
    wait_cycles(5 * FRAME);
    bus.game_state = 3'd0;
    wait_cycles(2 * FRAME);
    bus.game_state = 3'd6;
    wait_cycles(FRAME);
    bus.game_state = 3'd7;
    wait_cycles(FRAME);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      bus.result_valid = 1'b0;
      if ($urandom_range(0, 99) < 2) bus.game_state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3) bus.guess_digits = 16'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        bus.J1_points = 8'($urandom);
        bus.J2_points = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 2) begin
        bus.result_valid = 1'b1;
        bus.bull_count   = 3'($urandom_range(0, 7));
        bus.cow_count    = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clock);
    bus.result_valid = 1'b0;
    bus.game_state   = 3'd0;

    // Mid-scan reset while digit 5 is current.
    begin : find_idx5
      bit found;
      found = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
        if (((cyc / DIV) % 8) == 5 && (cyc % DIV) == 1) begin
          found = 1'b1;
          break;
        end
        @(negedge clock);
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL idx5_search got not_found exp found");
      end
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.AN !== 8'hFF || bus.DDP !== 8'hFF) begin
      miscompares++;
      $display("FAIL async_reset AN got %h exp ff DDP got %h exp ff", bus.AN, bus.DDP);
    end
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(3 * FRAME);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Drives the board's 8-digit multiplexed 7-segment display for the Bulls and Cows game.
- Time-shares the single segment bus DDP across the eight anodes AN, one digit at a time.
- Chooses what each digit shows from game_state, and runs a timed overlay that shows the bull/cow result after each guess.
- Sits beside the LED score block and shares its game-state inputs.

Parameters:
DIV, 100000, clock cycles per digit slot (scan tick period); legal range 2 or more.
HOLD_FRAMES, 250, number of full 8-digit frames the bull/cow result stays on screen.
BLINK_FRAMES, 60, number of frames per blink half-period in the win states.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
game_state  in  3  0=SETUP_J1, 1=SETUP_J2, 2=GUESS_J1, 3=GUESS_J2, 4=WIN_J1, 5=WIN_J2, 6-7=blank
guess_digits  in  16  four hex digits being entered; [15:12] is the leftmost
J1_points  in  8  player 1 score
J2_points  in  8  player 2 score
bull_count  in  3  bulls from the last guess
cow_count  in  3  cows from the last guess
result_valid  in  1  one-cycle pulse; bull_count/cow_count are valid in that cycle
AN  out  8  anodes, active-low, one-hot; AN[7] is the leftmost digit
DDP  out  8  segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a

Behaviour:
- Reset (reset=0, asynchronous): AN=8'hFF, DDP=8'hFF, prescaler=0, idx=0, mode=NORMAL, hold=0, blink counter=0, blink_on=1, latched bull/cow=0.
- Prescaler counts 0..DIV-1. The cycle where it equals DIV-1 is a tick. On a tick, idx advances (idx 7 wraps to 0); the 7->0 wrap is a frame pulse.
- AN and DDP are registered and update on the cycle after idx changes.
  - AN = ~(1<<idx).
  - DDP = glyph for digit idx.
  - When blanked, AN=8'hFF.
- DP is always off (DDP[7]=1).
- Glyphs (values given as DDP): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, J=E1, c=A7, blank=FF.
- Mode FSM, two states:
  - NORMAL: result_valid latches bull/cow, sets hold=HOLD_FRAMES, and goes to RESULT.
  - RESULT:
    - Each frame pulse decrements hold; when hold reaches 0, return to NORMAL.
    - result_valid in RESULT re-latches bull/cow and reloads hold.
    - A game_state change in RESULT (versus the previous cycle) aborts to NORMAL, unless result_valid is high in the same cycle; result_valid wins and RESULT is (re)entered.
- Content, digit 7 leftmost down to digit 0:
  - SETUP_Jn and GUESS_Jn (NORMAL): 7='J', 6=n, 5-4=blank, 3-0=guess_digits nibbles (hex).
  - RESULT: 7='b', 6=bull (0-7), 5=blank, 4='c', 3=cow (0-7), 2-0=blank.
  - WIN_Jn: 7='J', 6=n, 5-2=blank, 1-0=winner's points as hex (J1_points or J2_points).
  - When blink_on=0, all anodes are off.
  - game_state 6 or 7: AN=8'hFF.
- Blink:
  - Active only in WIN states. The blink counter counts frames; when it reaches BLINK_FRAMES, blink_on toggles and the counter clears.
  - On entry to any non-WIN state, blink_on is forced to 1 and the counter cleared.
- Inputs are sampled every cycle. A content change shows on the next slot render, with no tear within a slot.
- Reset mid-scan returns to the reset values immediately. After reset release, the first tick occurs DIV cycles later.

Test Plan:
- DIV=4, game_state=0, guess_digits=16'h1234, release reset -> AN steps FE, FD, ... 7F every 4 cycles. Digit 0 DDP=99 ('4'), digit 3 DDP=F9 ('1'), digit 7 DDP=E1 ('J'), digit 6 DDP=F9 ('1'), digits 5 and 4 DDP=FF.
- game_state=2, pulse result_valid with bull=2 and cow=1, HOLD_FRAMES=3 -> digits 7,6,4,3 show 83, A4, A7, F9 for exactly 3 frames (96 cycles at DIV=4), then the guess view returns.
- In RESULT, change game_state 2->3 with no result_valid -> NORMAL on the next cycle; digit 6 shows A4 ('2').
- In RESULT, second result_valid at frame 2 with bull=4 -> digit 6 shows 99 and hold reloads to 3 frames.
- game_state=4, J1_points=8'h0A, BLINK_FRAMES=2 -> digits 1 and 0 show C0 and 88. AN toggles between scanning and FF every 2 frames; switching to game_state=0 restores scanning at once.
- Assert reset=0 mid-frame with idx=5 -> AN=FF and DDP=FF in the same cycle. After release, the first anode is FE, DIV cycles later.
